rom_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the instruction ROM's write port. It consumes a framed byte stream (from a UART receiver or debug bridge) and assembles little-endian 32-bit words. It writes them to consecutive word addresses through `wen`/`w_addr`/`w_data`. It holds the core via `cpu_hold` until a frame is fully loaded and its checksum verifies.

---
 rtl/rom_loader.sv | 170 +++++++++++++++++
 tb/tb_rom_loader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Boot-time ROM loader: parses an 0xA5-framed byte stream, writes little-endian words
// to consecutive ROM addresses and holds the core until the frame checksum verifies.
module rom_loader #(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   DW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int unsigned   MAX_WORDS = 4096,
  parameter int unsigned   TIMEOUT   = 1_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          wen,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int unsigned IW = $clog2(MAX_WORDS) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLen  = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StCsum = 3'd3;
  localparam logic [2:0] StDone = 3'd4;
  localparam logic [2:0] StErr  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [31:0]   full;
  logic [IW-1:0] n_q, n_d;
  logic [IW-1:0] word_idx_q, word_idx_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          in_frame;
  logic          abort;

  // The three previous bytes plus the current one form a complete little-endian word.
  assign full     = {rx_data, shift_q};
  assign in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    abort      = 1'b0;

    if (!in_frame) begin
      if (rx_valid && rx_data == 8'hA5) begin
        state_d    = StLen;
        byte_cnt_d = '0;
        word_idx_d = '0;
        csum_d     = '0;
        tmo_d      = '0;
        hold_d     = 1'b1;
        done_d     = 1'b0;
        err_d      = 1'b0;
      end
    end else if (rx_valid) begin
      tmo_d      = '0;
      shift_d    = full[31:8];
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (state_q)
        StLen: begin
          if (byte_cnt_q == 2'd3) begin
            if (full > 32'(MAX_WORDS)) begin
              abort = 1'b1;
            end else if (full == '0) begin
              state_d = StCsum;
            end else begin
              n_d     = IW'(full);
              state_d = StData;
            end
          end
        end
        StData: begin
          csum_d = csum_q + rx_data;
          if (byte_cnt_q == 2'd3) begin
            wen_d      = 1'b1;
            addr_d     = BASE_ADDR + AW'({word_idx_q, 2'b00});
            data_d     = DW'(full);
            word_idx_d = word_idx_q + IW'(1);
            if (word_idx_d == n_q) state_d = StCsum;
          end
        end
        default: begin
          if (rx_data == csum_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            abort = 1'b1;
          end
        end
      endcase
    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
      abort = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (abort) begin
      state_d = StErr;
      err_d   = 1'b1;
      hold_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      n_q        <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      wen_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      data_q     <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign wen      = wen_q;
  assign w_addr   = addr_q;
  assign w_data   = data_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: directed vector table, multi-cycle corner
// sequences and random byte streams checked against a frame-parsing reference model.
module tb_rom_loader;

  localparam int unsigned TMO  = 16;
  localparam int unsigned MAXW = 4096;
  localparam logic [31:0] BASE = 32'h0;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        wen;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  rom_loader #(
    .AW       (32),
    .DW       (32),
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .TIMEOUT  (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .wen     (wen),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  s_byte[$];
  int unsigned s_gap[$];
  logic        m_done, m_err, m_hold;

  always @(negedge clk) begin
    if (wen === 1'b1) begin
      cap_addr.push_back(w_addr);
      cap_data.push_back(w_data);
    end
  end

  typedef struct {
    int           nb;
    logic [127:0] bytes;  // stream order, first byte most significant
    int           nwr;
    logic [31:0]  last_addr;
    logic [31:0]  last_data;
    logic         done;
    logic         err;
    logic         hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic drive_stream();
    cap_addr.delete();
    cap_data.delete();
    for (int i = 0; i < s_byte.size(); i++) begin
      repeat (s_gap[i] - 1) tick();
      put(s_byte[i]);
    end
    repeat (TMO + 5) tick();
  endtask

  function automatic int unsigned pick_gap();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 82) return 1;
    if (r < 97) return $urandom_range(2, 4);
    return TMO + 3;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    s_byte.push_back(b);
    s_gap.push_back(pick_gap());
  endtask

  function automatic bit avail(input int unsigned i);
    return (i < s_byte.size()) && (s_gap[i] <= TMO);
  endfunction

  // Walks the stream frame by frame; a frame ends on checksum, on a rejected length,
  // or at the first byte that is missing or arrives after too long a gap.
  task automatic run_model();
    int unsigned i;
    bit          ok;
    logic [31:0] len;
    logic [31:0] w;
    logic [7:0]  cs;
    exp_addr.delete();
    exp_data.delete();
    i = 0;
    while (i < s_byte.size()) begin
      if (s_byte[i] != 8'hA5) begin
        i++;
      end else begin
        m_done = 1'b0;
        m_err  = 1'b0;
        m_hold = 1'b1;
        i++;
        ok  = 1'b1;
        len = '0;
        cs  = '0;
        w   = '0;
        for (int k = 0; k < 4; k++) begin
          if (ok && avail(i)) begin
            len[8*k +: 8] = s_byte[i];
            i++;
          end else begin
            ok = 1'b0;
          end
        end
        if (ok && len > MAXW) ok = 1'b0;
        for (longint unsigned wi = 0; ok && wi < longint'(len); wi++) begin
          for (int k = 0; k < 4; k++) begin
            if (ok && avail(i)) begin
              w[8*k +: 8] = s_byte[i];
              cs = cs + s_byte[i];
              i++;
            end else begin
              ok = 1'b0;
            end
          end
          if (ok) begin
            exp_addr.push_back(BASE + 32'(wi * 4));
            exp_data.push_back(w);
          end
        end
        if (ok && avail(i)) begin
          if (s_byte[i] == cs) begin
            m_done = 1'b1;
            m_hold = 1'b0;
          end else begin
            m_err = 1'b1;
          end
          i++;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  initial begin
    vec_t        v;
    int unsigned n;
    int unsigned ndata;
    logic [7:0]  b;
    logic [7:0]  cs;

    vecs[0] = '{14, 128'hA5_02_00_00_00_78_56_34_12_EF_BE_AD_DE_4C, 2, 32'h4, 32'hDEADBEEF,
                1'b1, 1'b0, 1'b0};
    vecs[1] = '{6, 128'hA5_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{6, 128'hA5_00_00_00_00_01, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{14, 128'hA5_02_00_00_00_78_56_34_12_EF_BE_AD_DE_71, 2, 32'h4, 32'hDEADBEEF,
                1'b0, 1'b1, 1'b1};
    vecs[4] = vecs[0];
    vecs[5] = '{8, 128'hA5_01_10_00_00_11_22_33, 0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{13, 128'h00_FF_5A_A5_01_00_00_00_01_02_03_04_0A, 1, 32'h0, 32'h04030201,
                1'b1, 1'b0, 1'b0};
    vecs[7] = '{14, 128'hA5_02_00_00_00_78_56_34_12_EF_BE_AD_DE_70, 2, 32'h4, 32'hDEADBEEF,
                1'b0, 1'b1, 1'b1};

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (2) tick();
    check("rst_wen", wen, 0);
    check("rst_addr", w_addr, BASE);
    check("rst_data", w_data, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // Back-to-back frame: write timing, single-cycle wen, no stall, done timing.
    put(8'hA5); put(8'h02); put(8'h00); put(8'h00); put(8'h00);
    put(8'h78); put(8'h56); put(8'h34); put(8'h12);
    check("w0_wen", wen, 1);
    check("w0_addr", w_addr, 32'h0);
    check("w0_data", w_data, 32'h12345678);
    put(8'hEF);
    check("w0_wen_drop", wen, 0);
    put(8'hBE); put(8'hAD); put(8'hDE);
    check("w1_wen", wen, 1);
    check("w1_addr", w_addr, 32'h4);
    check("w1_data", w_data, 32'hDEADBEEF);
    check("pre_cs_done", done, 0);
    check("pre_cs_hold", cpu_hold, 1);
    put(8'h4C);
    check("cs_done", done, 1);
    check("cs_hold", cpu_hold, 0);
    check("cs_err", err, 0);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      s_byte.delete();
      s_gap.delete();
      for (int k = 0; k < v.nb; k++) begin
        s_byte.push_back(v.bytes[8*(v.nb-1-k) +: 8]);
        s_gap.push_back(1);
      end
      drive_stream();
      check($sformatf("vec%0d_nwr", i), cap_addr.size(), v.nwr);
      if (v.nwr > 0 && cap_addr.size() > 0) begin
        check($sformatf("vec%0d_addr", i), cap_addr[cap_addr.size()-1], v.last_addr);
        check($sformatf("vec%0d_data", i), cap_data[cap_data.size()-1], v.last_data);
      end
      check($sformatf("vec%0d_done", i), done, v.done);
      check($sformatf("vec%0d_err", i), err, v.err);
      check($sformatf("vec%0d_hold", i), cpu_hold, v.hold);
    end

    // Timeout: err exactly TMO cycles after the last accepted byte, one write kept.
    cap_addr.delete();
    cap_data.delete();
    put(8'hA5); put(8'h02); put(8'h00); put(8'h00); put(8'h00);
    for (int k = 1; k <= 6; k++) put(8'(k));
    for (int k = 1; k <= int'(TMO); k++) begin
      tick();
      if (k == int'(TMO) - 1) check("tmo_early", err, 0);
    end
    check("tmo_err", err, 1);
    check("tmo_hold", cpu_hold, 1);
    check("tmo_nwr", cap_addr.size(), 1);

    // Length exactly MAX_WORDS is accepted (then times out waiting for data).
    put(8'hA5); put(8'h00); put(8'h10); put(8'h00); put(8'h00);
    check("maxw_accept", err, 0);
    repeat (TMO + 5) tick();
    check("maxw_tmo", err, 1);

    // Reset mid-word: same-cycle byte ignored, outputs back to reset, nothing written.
    put(8'hA5); put(8'h01); put(8'h00); put(8'h00); put(8'h00);
    put(8'h11); put(8'h22); put(8'h33);
    cap_addr.delete();
    cap_data.delete();
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h44;
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    check("mrst_wen", wen, 0);
    check("mrst_addr", w_addr, BASE);
    check("mrst_data", w_data, 0);
    check("mrst_hold", cpu_hold, 1);
    check("mrst_err", err, 0);
    repeat (3) tick();
    check("mrst_nwr", cap_addr.size(), 0);
    put(8'hA5); put(8'h01); put(8'h00); put(8'h00); put(8'h00);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'hAA);
    check("post_rst_done", done, 1);
    check("post_rst_hold", cpu_hold, 0);
    check("post_rst_nwr", cap_addr.size(), 1);
    if (cap_data.size() > 0) check("post_rst_data", cap_data[0], 32'h44332211);
    repeat (TMO + 5) tick();

    m_done = 1'b1;
    m_err  = 1'b0;
    m_hold = 1'b0;
    for (int it = 0; it < 25; it++) begin
      s_byte.delete();
      s_gap.delete();
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) push_byte(8'($urandom_range(0, 255)));
        push_byte(8'hA5);
        n = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW + 1, 70000) : $urandom_range(0, 4);
        for (int k = 0; k < 4; k++) push_byte(n[8*k +: 8]);
        if (n <= 4) begin
          ndata = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4 * n) : 4 * n + 1;
          cs = '0;
          for (int k = 0; k < int'(4 * n) && k < int'(ndata); k++) begin
            b = 8'($urandom_range(0, 255));
            cs = cs + b;
            push_byte(b);
          end
          if (ndata > 4 * n) begin
            if ($urandom_range(0, 3) == 0) push_byte(cs + 8'($urandom_range(1, 255)));
            else push_byte(cs);
          end
        end
      end
      drive_stream();
      run_model();
      check($sformatf("rnd%0d_nwr", it), cap_addr.size(), exp_addr.size());
      for (int k = 0; k < exp_addr.size() && k < cap_addr.size(); k++) begin
        check($sformatf("rnd%0d_addr%0d", it, k), cap_addr[k], exp_addr[k]);
        check($sformatf("rnd%0d_data%0d", it, k), cap_data[k], exp_data[k]);
      end
      check($sformatf("rnd%0d_done", it), done, m_done);
      check($sformatf("rnd%0d_err", it), err, m_err);
      check($sformatf("rnd%0d_hold", it), cpu_hold, m_hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
